// File: rtl/c4_stim_ser.sv
// c4_stim_ser: parallel-to-serial stimulus source for the c4 state machine.
// A frame of up to W bits is captured on an accepted load and shifted out
// one bit per falling edge of n_clk on `a`. `a` is parked at 0 outside frames.
//
// Handshake: `load` is a level request sampled on the falling edge. It is
// accepted in IDLE, and also on the edge that leaves DONE, so a source that
// holds `load` high gets back-to-back frames separated by exactly one a=0
// cycle. `clr` on an edge overrides everything and returns to IDLE.
module c4_stim_ser #(
    parameter int W         = 16,
    parameter bit MSB_FIRST = 1'b0,
    localparam int LW       = $clog2(W + 1)
) (
    input  logic          n_clk,
    input  logic          rst,
    input  logic [W-1:0]  data,
    input  logic [LW-1:0] len,
    input  logic          load,
    input  logic          clr,
    output logic          ready,
    output logic          busy,
    output logic          a,
    output logic          done,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  shreg_q;
    logic [LW-1:0] cnt_q;
    logic          a_q;
    logic          busy_q;
    logic          done_q;
    logic          ready_q;

    logic [LW-1:0] eff_len;
    logic [W-1:0]  aligned;
    logic          first_bit;
    logic [W-1:0]  load_rest;
    logic          next_bit;
    logic [W-1:0]  shifted;

    // Effective length, first bit and remaining bits of a frame being loaded,
    // plus the next bit / shifted value for a frame already in flight.
    // For MSB-first the frame is left-aligned so the send bit is always [W-1].
    always_comb begin
        eff_len   = (len == '0 || len > LW'(W)) ? LW'(W) : len;
        aligned   = data;
        first_bit = data[0];
        load_rest = data >> 1;
        next_bit  = shreg_q[0];
        shifted   = shreg_q >> 1;
        if (MSB_FIRST) begin
            aligned   = data << (LW'(W) - eff_len);
            first_bit = aligned[W-1];
            load_rest = aligned << 1;
            next_bit  = shreg_q[W-1];
            shifted   = shreg_q << 1;
        end
    end

    // Frame FSM with registered serial output and status flags.
    always_ff @(negedge n_clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else if (clr) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_SHIFT: begin
                    if (cnt_q != '0) begin
                        a_q     <= next_bit;
                        shreg_q <= shifted;
                        cnt_q   <= cnt_q - LW'(1);
                    end else begin
                        state_q <= S_DONE;
                        a_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a load; DONE otherwise falls to IDLE.
                    if (load) begin
                        state_q <= S_SHIFT;
                        shreg_q <= load_rest;
                        cnt_q   <= eff_len - LW'(1);
                        a_q     <= first_bit;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        a_q     <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign a         = a_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_c4_stim_ser.sv
// Bench for c4_stim_ser: one LSB-first and one MSB-first instance share inputs.
module tb_c4_stim_ser;
    localparam int W  = 16;
    localparam int LW = $clog2(W + 1);

    logic          n_clk = 1'b1;
    logic          rst   = 1'b1;
    logic          load  = 1'b0;
    logic          clr   = 1'b0;
    logic [W-1:0]  data  = '0;
    logic [LW-1:0] len   = '0;

    logic ready0, busy0, a0, done0;
    logic ready1, busy1, a1, done1;
    logic [1:0] st0, st1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected per-cycle outputs {a, busy, done, ready}; empty queue means idle.
    logic [3:0] exp0_q[$];
    logic [3:0] exp1_q[$];

    typedef struct {
        logic [W-1:0]  data;
        logic [LW-1:0] len;
        int            n;
        logic [W-1:0]  bits0;
        logic [W-1:0]  bits1;
    } vec_t;
    vec_t vecs[7];

    always #5 n_clk = ~n_clk;

    c4_stim_ser #(.W(W), .MSB_FIRST(1'b0)) dut0 (
        .n_clk(n_clk), .rst(rst), .data(data), .len(len), .load(load), .clr(clr),
        .ready(ready0), .busy(busy0), .a(a0), .done(done0), .dbg_state(st0)
    );

    c4_stim_ser #(.W(W), .MSB_FIRST(1'b1)) dut1 (
        .n_clk(n_clk), .rst(rst), .data(data), .len(len), .load(load), .clr(clr),
        .ready(ready1), .busy(busy1), .a(a1), .done(done1), .dbg_state(st1)
    );

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    function automatic int eff_len(input logic [LW-1:0] l);
        return (l == 0 || int'(l) > W) ? W : int'(l);
    endfunction

    // A frame is L bit cycles followed by one done cycle.
    task automatic push_frame(input bit msb, input logic [W-1:0] d, input logic [LW-1:0] l);
        int n;
        logic b;
        n = eff_len(l);
        for (int i = 0; i < n; i++) begin
            b = msb ? d[n-1-i] : d[i];
            if (msb) exp1_q.push_back({b, 3'b100});
            else     exp0_q.push_back({b, 3'b100});
        end
        if (msb) exp1_q.push_back(4'b0010);
        else     exp0_q.push_back(4'b0010);
    endtask

    // One falling edge of the reference: consume the cycle that ends; if
    // nothing is left, a held load starts a new frame.
    task automatic model_edge();
        if (!rst || clr) begin
            exp0_q.delete();
            exp1_q.delete();
        end else begin
            if (exp0_q.size() > 0) void'(exp0_q.pop_front());
            if (exp1_q.size() > 0) void'(exp1_q.pop_front());
            if (load && exp0_q.size() == 0) push_frame(1'b0, data, len);
            if (load && exp1_q.size() == 0) push_frame(1'b1, data, len);
        end
    endtask

    task automatic check_model();
        logic [3:0] e0, e1;
        e0 = (exp0_q.size() > 0) ? exp0_q[0] : 4'b0001;
        e1 = (exp1_q.size() > 0) ? exp1_q[0] : 4'b0001;
        check("model_lsb", {a0, busy0, done0, ready0}, e0);
        check("model_msb", {a1, busy1, done1, ready1}, e1);
    endtask

    // Apply inputs, take one falling edge, sample #1 later against the model.
    task automatic step(input logic ld, input logic cl, input logic [W-1:0] d, input logic [LW-1:0] l);
        load = ld; clr = cl; data = d; len = l;
        @(negedge n_clk);
        model_edge();
        #1;
        check_model();
    endtask

    function automatic logic [W-1:0] rnd_data();
        return W'($urandom);
    endfunction

    int n_done;

    initial begin
        vecs[0] = '{16'h01E9, 5'd10, 10, 16'h01E9, 16'h025E};
        vecs[1] = '{16'h00B0, 5'd8,  8,  16'h00B0, 16'h000D};
        vecs[2] = '{16'h00B0, 5'd0,  16, 16'h00B0, 16'h0D00};
        vecs[3] = '{16'h0001, 5'd1,  1,  16'h0001, 16'h0001};
        vecs[4] = '{16'h0007, 5'd3,  3,  16'h0007, 16'h0007};
        vecs[5] = '{16'h8001, 5'd20, 16, 16'h8001, 16'h8001};
        vecs[6] = '{16'hFFF2, 5'd5,  5,  16'h0012, 16'h0009};

        // Reset state
        #2 rst = 1'b0;
        #1;
        check("reset_lsb", {a0, busy0, done0, ready0}, 4'b0001);
        check("reset_msb", {a1, busy1, done1, ready1}, 4'b0001);
        repeat (2) @(negedge n_clk);
        #2 rst = 1'b1;
        @(negedge n_clk);
        #1;
        check_model();

        // Table-driven frames; data/len scrambled during each frame
        foreach (vecs[v]) begin
            step(1'b1, 1'b0, vecs[v].data, vecs[v].len);
            check("tbl_a_lsb", {3'b0, a0}, {3'b0, vecs[v].bits0[0]});
            check("tbl_a_msb", {3'b0, a1}, {3'b0, vecs[v].bits1[0]});
            for (int i = 1; i < vecs[v].n; i++) begin
                step(1'b0, 1'b0, rnd_data(), LW'($urandom_range(0, 31)));
                check("tbl_a_lsb", {3'b0, a0}, {3'b0, vecs[v].bits0[i]});
                check("tbl_a_msb", {3'b0, a1}, {3'b0, vecs[v].bits1[i]});
            end
            step(1'b0, 1'b0, rnd_data(), LW'($urandom_range(0, 31)));
            check("tbl_done", {a0, busy0, done0, ready0}, 4'b0010);
            step(1'b0, 1'b0, rnd_data(), LW'($urandom_range(0, 31)));
            check("tbl_ready", {a0, busy0, done0, ready0}, 4'b0001);
        end

        // Load pulsed mid-frame is ignored
        step(1'b1, 1'b0, 16'h01E9, 5'd10);
        step(1'b0, 1'b0, 16'h0000, 5'd10);
        step(1'b1, 1'b0, 16'hFFFF, 5'd2);
        check("ign_load_a", {3'b0, a0}, 4'b0000);
        repeat (9) step(1'b0, 1'b0, 16'h0000, 5'd0);
        check("ign_load_idle", {a0, busy0, done0, ready0}, 4'b0001);

        // clr at bit 2 of a 10-bit frame
        step(1'b1, 1'b0, 16'h03FF, 5'd10);
        step(1'b0, 1'b0, 16'h03FF, 5'd10);
        step(1'b0, 1'b0, 16'h03FF, 5'd10);
        check("clr_pre", {a0, busy0, done0, ready0}, 4'b1100);
        step(1'b0, 1'b1, 16'h03FF, 5'd10);
        check("clr_abort", {a0, busy0, done0, ready0}, 4'b0001);
        step(1'b0, 1'b0, 16'h03FF, 5'd10);
        check("clr_no_done", {3'b0, done0}, 4'b0000);

        // clr together with load rejects the load
        step(1'b1, 1'b1, 16'hFFFF, 5'd4);
        check("clr_load", {a0, busy0, done0, ready0}, 4'b0001);
        step(1'b0, 1'b0, 16'hFFFF, 5'd4);

        // Back-to-back with load held: 1,1,1,0 repeating
        n_done = 0;
        for (int j = 0; j < 12; j++) begin
            step(1'b1, 1'b0, 16'h0007, 5'd3);
            check("b2b_a", {3'b0, a0}, {3'b0, logic'((j % 4) != 3)});
            if (done0) n_done++;
        end
        check("b2b_dones", 4'(n_done), 4'd3);
        repeat (5) step(1'b0, 1'b0, 16'h0000, 5'd0);

        // Asynchronous reset mid-frame
        step(1'b1, 1'b0, 16'hFFFF, 5'd16);
        repeat (3) step(1'b0, 1'b0, 16'hFFFF, 5'd16);
        check("rst_pre_a", {3'b0, a0}, 4'b0001);
        #2 rst = 1'b0;
        #1;
        exp0_q.delete();
        exp1_q.delete();
        check("rst_async_lsb", {a0, busy0, done0, ready0}, 4'b0001);
        check("rst_async_msb", {a1, busy1, done1, ready1}, 4'b0001);
        @(negedge n_clk);
        #1;
        check("rst_hold", {a0, busy0, done0, ready0}, 4'b0001);
        #2 rst = 1'b1;
        repeat (3) begin
            step(1'b0, 1'b0, 16'h0000, 5'd0);
            check("rst_after_no_done", {3'b0, done0}, 4'b0000);
        end

        // Randomized traffic against the reference queues
        for (int r = 0; r < 2000; r++) begin
            step(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 19) == 0),
                 rnd_data(), LW'($urandom_range(0, 31)));
        end

        load = 1'b0;
        clr  = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
